// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Purpose  : Default 640x480@60 VGA timing constants, derived totals and
//             sync window bounds, shared with the downstream pixel generator.
//  Revision : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_cnt_w = 10;

    typedef logic [c_cnt_w-1:0] count_t;

    // Horizontal timing in pixels
    localparam int c_h_visible = 640;
    localparam int c_h_front   = 16;
    localparam int c_h_sync    = 96;
    localparam int c_h_back    = 48;
    localparam int c_h_total   = c_h_visible + c_h_front + c_h_sync + c_h_back;

    // Vertical timing in lines
    localparam int c_v_visible = 480;
    localparam int c_v_front   = 10;
    localparam int c_v_sync    = 2;
    localparam int c_v_back    = 33;
    localparam int c_v_total   = c_v_visible + c_v_front + c_v_sync + c_v_back;

    // Sync windows are half-open: [start, end)
    localparam int c_hs_start  = c_h_visible + c_h_front;
    localparam int c_hs_end    = c_hs_start + c_h_sync;
    localparam int c_vs_start  = c_v_visible + c_v_front;
    localparam int c_vs_end    = c_vs_start + c_v_sync;

    // Unsigned test of lo <= cnt < hi
    function automatic logic in_window(input count_t cnt, input count_t lo, input count_t hi);
        return (cnt >= lo) && (cnt < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter
//  Purpose  : Modulo-N up counter with enable. Exposes the registered count,
//             the count it will take on the next edge, and a wrap strobe
//             that is high on the enabled cycle that returns it to zero.
//  Revision : 1.0  initial release
// ============================================================================
module mod_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_count_next,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;
    logic             w_wrap;

    // Next count: >= guards against ever sitting above the last value
    always_comb begin
        w_wrap = i_en && (r_count >= c_last);
        w_next = r_count;
        if (i_en) begin
            w_next = w_wrap ? '0 : (r_count + WIDTH'(1));
        end
    end

    // Count register; reset parks on the last value so the first enable wraps to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= c_last;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_next;
    assign o_wrap       = w_wrap;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : VGA raster timing. Horizontal and vertical modulo counters with
//             sync, visible-area and line/frame start flags, all registered
//             from next-state counts so flags align with HCOUNT/VCOUNT.
//  Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = c_h_visible,
    parameter int H_FRONT   = c_h_front,
    parameter int H_SYNC    = c_h_sync,
    parameter int H_BACK    = c_h_back,
    parameter int V_VISIBLE = c_v_visible,
    parameter int V_FRONT   = c_v_front,
    parameter int V_SYNC    = c_v_sync,
    parameter int V_BACK    = c_v_back
) (
    input  logic         CLKIN,
    input  logic         RESET,
    input  logic         PIXEL_EN,
    output logic [9:0]   HCOUNT,
    output logic [9:0]   VCOUNT,
    output logic         HSYNC_L,
    output logic         VSYNC_L,
    output logic         VIDEO_ON,
    output logic         LINE_START,
    output logic         FRAME_START
);

    localparam int     c_htot     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int     c_vtot     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam count_t c_hvis     = c_cnt_w'(H_VISIBLE);
    localparam count_t c_vvis     = c_cnt_w'(V_VISIBLE);
    localparam count_t c_hs_lo    = c_cnt_w'(H_VISIBLE + H_FRONT);
    localparam count_t c_hs_hi    = c_cnt_w'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam count_t c_vs_lo    = c_cnt_w'(V_VISIBLE + V_FRONT);
    localparam count_t c_vs_hi    = c_cnt_w'(V_VISIBLE + V_FRONT + V_SYNC);

    count_t w_h_count;
    count_t w_h_next;
    count_t w_v_count;
    count_t w_v_next;
    logic   w_h_wrap;
    logic   w_v_wrap;
    logic   w_hs_active;
    logic   w_vs_active;
    logic   w_visible;

    logic   r_hsync_l;
    logic   r_vsync_l;
    logic   r_video_on;
    logic   r_line_start;
    logic   r_frame_start;

    mod_counter #(
        .MODULUS (c_htot),
        .WIDTH   (c_cnt_w)
    ) u_hcnt (
        .clk          (CLKIN),
        .rst          (RESET),
        .i_en         (PIXEL_EN),
        .o_count      (w_h_count),
        .o_count_next (w_h_next),
        .o_wrap       (w_h_wrap)
    );

    // The vertical counter steps once per line, on the horizontal wrap
    mod_counter #(
        .MODULUS (c_vtot),
        .WIDTH   (c_cnt_w)
    ) u_vcnt (
        .clk          (CLKIN),
        .rst          (RESET),
        .i_en         (w_h_wrap),
        .o_count      (w_v_count),
        .o_count_next (w_v_next),
        .o_wrap       (w_v_wrap)
    );

    // Decode flags from the counts the registers will hold after this edge
    always_comb begin
        w_hs_active = in_window(w_h_next, c_hs_lo, c_hs_hi);
        w_vs_active = in_window(w_v_next, c_vs_lo, c_vs_hi);
        w_visible   = (w_h_next < c_hvis) && (w_v_next < c_vvis);
    end

    // Output flag registers; a vertical wrap only occurs on a horizontal wrap,
    // so it marks exactly the edge on which the raster enters (0,0)
    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            r_hsync_l     <= 1'b1;
            r_vsync_l     <= 1'b1;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync_l     <= ~w_hs_active;
            r_vsync_l     <= ~w_vs_active;
            r_video_on    <= w_visible;
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    assign HCOUNT      = w_h_count;
    assign VCOUNT      = w_v_count;
    assign HSYNC_L     = r_hsync_l;
    assign VSYNC_L     = r_vsync_l;
    assign VIDEO_ON    = r_video_on;
    assign LINE_START  = r_line_start;
    assign FRAME_START = r_frame_start;

endmodule
`default_nettype wire
